fir2d_param_filter: RTL
=======================

FIR2D_PARAM_FILTER -- requirements
Module: fir2d_param_filter

Interface
REQ-001 Parameter K, 5, kernel size; legal values 3 or 5.
REQ-002 Parameter PIX_W, 8, pixel width (unsigned).
REQ-003 Parameter COEFF_W, 16, coefficient width (signed).
REQ-004 Parameter FRAC_BITS, 8, coefficient fractional bits.
REQ-005 Parameter MAX_W, 2048, maximum active pixels per line.
REQ-006 Single clock and reset: one clock; reset is synchronous and active-high (ports clk, rst).
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 y_i / dv_i / hs_i / vs_i  in  PIX_W/1/1/1  input pixel, data valid, hsync, vsync.
REQ-010 coef_wr_valid / coef_wr_ready  in/out  1/1  coefficient write handshake.
REQ-011 coef_wr_idx / coef_wr_data  in  5/COEFF_W  tap index (r*K+c), signed value.
REQ-012 y_o / dv_o / hs_o / vs_o  out  PIX_W/1/1/1  filtered pixel and delayed syncs.
REQ-013 x_index / y_index  out  11/10  column and line counters of the current input.

Function
REQ-014 x_index SHALL increment per dv_i=1 sample, clear on hs_i rising edge; y_index SHALL increment on hs_i rising edge when the ended line had at least one valid sample, clear on vs_i rising edge.
REQ-015 K-1 line memories of depth MAX_W SHALL be written at address x_index only when dv_i=1; window shift likewise only when dv_i=1.
REQ-016 Tap (r,c): r=0 current line, r=K-1 oldest line; c=0 newest pixel; tap uses coefficient index r*K+c.
REQ-017 Products SHALL be PIX_W+1-bit signed x COEFF_W, summed at full width (PIX_W+COEFF_W+5 bits), no intermediate truncation.
REQ-018 Result SHALL be sum + 2^(FRAC_BITS-1), arithmetic shift right FRAC_BITS, saturated to [0, 2^PIX_W-1].
REQ-019 Pipeline SHALL be 3 stages (window capture, products, sum/round/saturate); y_o valid exactly 3 cycles after the dv_i=1 sample; dv_o/hs_o/vs_o equal dv_i/hs_i/vs_i delayed 3 cycles.
REQ-020 y_o SHALL be 0 whenever dv_o=0.
REQ-021 Coefficient writes SHALL land in a shadow bank when coef_wr_valid and coef_wr_ready are both 1; index >= K*K accepted and discarded.
REQ-022 Shadow bank SHALL be copied to the active bank in the cycle a vs_i rising edge is detected; coef_wr_ready SHALL be 0 in that cycle only, 1 otherwise.
REQ-023 Active coefficients SHALL not change mid-frame.
REQ-024 Samples with x_index >= MAX_W SHALL not write line memory; their output uses the last stored column.

Reset
REQ-025 rst SHALL clear x_index, y_index, pipeline, dv_o/hs_o/vs_o and y_o to 0, and coef_wr_ready to 1.
REQ-026 rst SHALL load shadow and active banks with zeros except index 0 = 2^FRAC_BITS (pass-through).
REQ-027 Line memory contents SHALL be left uninitialised; rst mid-frame discards in-flight pixels, no output until the next dv_i.

Configuration
REQ-028 Macro FIR2D_BORDER_ZERO_EN: when defined, taps with row r > y_index or column c > x_index SHALL read 0; when undefined, they read stale line-memory/window content unchanged.

Verification
REQ-029 After reset, K=5, ramp input 0..255 on one line -> y_o equals input delayed 3 cycles, dv_o aligned.
REQ-030 Write all 25 taps = 256 (1.0), flat input 200, 6th line onward -> y_o = 255 (saturated).
REQ-031 Single tap index 6 = -256, flat input 50 -> y_o = 0 (negative clamp); index 6 = 128, input 3 -> y_o = 2 (round half up).
REQ-032 Coefficient write mid-frame -> output unchanged until after next vs_i rising edge; coef_wr_ready low exactly in the commit cycle.
REQ-033 coef_wr_idx = 25, data 0x7FFF -> no output change after commit.
REQ-034 FIR2D_BORDER_ZERO_EN defined, all taps 256/25-ish (10), flat 100, first line -> y_o = 4 at x_index 0 (only tap 0,0 active), rising to 20 at x_index 4.

Source files
------------

// File: rtl/fir2d_param_filter.sv
// fir2d_param_filter: streaming K x K 2-D FIR filter with double-buffered coefficients.
//
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   y_i, dv_i, hs_i, vs_i         input pixel, data valid, hsync, vsync
//   coef_wr_valid/_ready          coefficient write handshake into the shadow bank
//   coef_wr_idx, coef_wr_data     tap index (r*K+c) and signed fixed-point value
//   y_o, dv_o, hs_o, vs_o         filtered pixel and syncs, 3 cycles after input
//   x_index, y_index              column / line counters of the current input
//
// Optional build macro FIR2D_BORDER_ZERO_EN: taps above the first line or left of
// the first column read 0 instead of stale line-memory / window content.
module fir2d_param_filter #(
    parameter int unsigned K         = 5,
    parameter int unsigned PIX_W     = 8,
    parameter int unsigned COEFF_W   = 16,
    parameter int unsigned FRAC_BITS = 8,
    parameter int unsigned MAX_W     = 2048
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PIX_W-1:0]          y_i,
    input  logic                      dv_i,
    input  logic                      hs_i,
    input  logic                      vs_i,
    input  logic                      coef_wr_valid,
    output logic                      coef_wr_ready,
    input  logic [4:0]                coef_wr_idx,
    input  logic signed [COEFF_W-1:0] coef_wr_data,
    output logic [PIX_W-1:0]          y_o,
    output logic                      dv_o,
    output logic                      hs_o,
    output logic                      vs_o,
    output logic [10:0]               x_index,
    output logic [9:0]                y_index
);

    localparam int unsigned NTAP   = K * K;
    localparam int unsigned PROD_W = PIX_W + 1 + COEFF_W;
    localparam int unsigned SUM_W  = PIX_W + COEFF_W + 5;
    localparam int unsigned AW     = $clog2(MAX_W);

    localparam logic signed [COEFF_W-1:0] UNITY    = COEFF_W'(2 ** FRAC_BITS);
    localparam logic signed [SUM_W-1:0]   ROUND    = SUM_W'(2 ** (FRAC_BITS - 1));
    localparam logic signed [SUM_W-1:0]   PIX_MAXV = SUM_W'((2 ** PIX_W) - 1);

    // ---------------- sync edge detection and position counters ----------------
    logic hs_q, vs_q;
    logic hs_rise, vs_rise;

    assign hs_rise = hs_i & ~hs_q;
    assign vs_rise = vs_i & ~vs_q;

    // Ready drops only in the bank-commit cycle so no write can race the copy.
    assign coef_wr_ready = rst | ~vs_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            x_index <= '0;
            y_index <= '0;
        end else begin
            hs_q <= hs_i;
            vs_q <= vs_i;
            if (hs_rise) begin
                x_index <= '0;
            end else if (dv_i && (x_index != '1)) begin
                x_index <= x_index + 11'd1;
            end
            if (vs_rise) begin
                y_index <= '0;
            end else if (hs_rise && (x_index != '0)) begin
                y_index <= y_index + 10'd1;
            end
        end
    end

    // ---------------- line memories ----------------
    // line_mem[0] holds the previous line, line_mem[K-2] the oldest one.
    logic [PIX_W-1:0] line_mem [K-1][MAX_W];
    logic             in_range;
    logic [AW-1:0]    mem_addr;
    logic [PIX_W-1:0] col [K];

    assign in_range = ({1'b0, x_index} < 12'(MAX_W));
    // Columns past the memory width reuse the last stored column.
    assign mem_addr = in_range ? x_index[AW-1:0] : AW'(MAX_W - 1);

    always_ff @(posedge clk) begin
        if (dv_i && in_range) begin
            line_mem[0][mem_addr] <= y_i;
            for (int r = 1; r < int'(K) - 1; r++) begin
                line_mem[r][mem_addr] <= line_mem[r-1][mem_addr];
            end
        end
    end

    always_comb begin
        col[0] = y_i;
        for (int r = 1; r < int'(K); r++) begin
            col[r] = line_mem[r-1][mem_addr];
        end
    end

    // ---------------- stage 1: window capture ----------------
    logic [PIX_W-1:0] win_q [K][K];
    logic [2:0]       dv_d, hs_d, vs_d;
`ifdef FIR2D_BORDER_ZERO_EN
    logic [10:0]      x1_q;
    logic [9:0]       y1_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < int'(K); r++) begin
                for (int c = 0; c < int'(K); c++) begin
                    win_q[r][c] <= '0;
                end
            end
`ifdef FIR2D_BORDER_ZERO_EN
            x1_q <= '0;
            y1_q <= '0;
`endif
        end else if (dv_i) begin
            for (int r = 0; r < int'(K); r++) begin
                win_q[r][0] <= col[r];
                for (int c = 1; c < int'(K); c++) begin
                    win_q[r][c] <= win_q[r][c-1];
                end
            end
`ifdef FIR2D_BORDER_ZERO_EN
            x1_q <= x_index;
            y1_q <= y_index;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dv_d <= '0;
            hs_d <= '0;
            vs_d <= '0;
        end else begin
            dv_d <= {dv_d[1:0], dv_i};
            hs_d <= {hs_d[1:0], hs_i};
            vs_d <= {vs_d[1:0], vs_i};
        end
    end

    assign dv_o = dv_d[2];
    assign hs_o = hs_d[2];
    assign vs_o = vs_d[2];

    // ---------------- coefficient banks ----------------
    logic signed [COEFF_W-1:0] shadow_q [NTAP];
    logic signed [COEFF_W-1:0] active_q [NTAP];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NTAP); i++) begin
                shadow_q[i] <= (i == 0) ? UNITY : '0;
                active_q[i] <= (i == 0) ? UNITY : '0;
            end
        end else begin
            if (vs_rise) begin
                for (int i = 0; i < int'(NTAP); i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
            // Indices >= K*K match no entry, so they are accepted and dropped.
            if (coef_wr_valid && coef_wr_ready) begin
                for (int i = 0; i < int'(NTAP); i++) begin
                    if (coef_wr_idx == 5'(i)) begin
                        shadow_q[i] <= coef_wr_data;
                    end
                end
            end
        end
    end

    // ---------------- stage 2: products ----------------
    logic signed [PROD_W-1:0] prod_d [NTAP];
    logic signed [PROD_W-1:0] prod_q [NTAP];

    always_comb begin
        for (int r = 0; r < int'(K); r++) begin
            for (int c = 0; c < int'(K); c++) begin
                logic [PIX_W-1:0] pix;
                pix = win_q[r][c];
`ifdef FIR2D_BORDER_ZERO_EN
                if ((r > int'(y1_q)) || (c > int'(x1_q))) begin
                    pix = '0;
                end
`endif
                prod_d[r*int'(K)+c] = $signed({1'b0, pix}) * active_q[r*int'(K)+c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NTAP); i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NTAP); i++) begin
                prod_q[i] <= prod_d[i];
            end
        end
    end

    // ---------------- stage 3: sum, round, saturate ----------------
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] shifted;
    logic [PIX_W-1:0]        sat;

    always_comb begin
        sum = ROUND;
        for (int i = 0; i < int'(NTAP); i++) begin
            sum = sum + SUM_W'(prod_q[i]);
        end
        shifted = sum >>> FRAC_BITS;
        if (shifted[SUM_W-1]) begin
            sat = '0;
        end else if (shifted > PIX_MAXV) begin
            sat = '1;
        end else begin
            sat = shifted[PIX_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_o <= '0;
        end else begin
            y_o <= dv_d[1] ? sat : '0;
        end
    end

endmodule
